cci_mpf_csr_event_counters: RTL and testbench
=============================================

Name: cci_mpf_csr_event_counters

Overview:
- Event accumulation stage directly downstream of the MPF shims' event wires (VTP, VC MAP, WRO, PWRITE); instantiated inside the MPF CSR manager.
- Registers single-cycle event pulses, sums each into a saturating counter, and serves indexed counter reads and clears issued by the CSR MMIO read/write logic.
- Has no host-side flow control: every read request produces exactly one response.

Parameters:
- N_EVENTS, 12, number of event inputs and counters.
- CTR_WIDTH, 48, counter width in bits; 1..64.
- IDX_WIDTH, 4, width of counter index fields; must satisfy 2^IDX_WIDTH >= N_EVENTS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- events  input  N_EVENTS  event pulses. Bit order: 0 4kb_hit, 1 4kb_miss, 2 2mb_hit, 3 2mb_miss, 4 pt_walk_busy, 5 failed_translation, 6 vc_map mapping_changed, 7 wro rr, 8 wro rw, 9 wro wr, 10 wro ww, 11 pwrite.
- rd_en  input  1  read request.
- rd_idx  input  IDX_WIDTH  counter to read.
- rd_valid  output  1  read response valid.
- rd_data  output  64  {overflow bit in bit 63, zeros, counter value zero-extended}.
- clr_en  input  1  clear one counter.
- clr_idx  input  IDX_WIDTH  counter to clear.
- clr_all  input  1  clear all counters.
- overflow  output  N_EVENTS  sticky per-counter saturation flags.

Behaviour:
- Reset:
  - Counters, overflow, the event pipeline register, rd_valid and rd_data all go to 0 on the first clk edge with reset high.
  - Reset mid-operation discards in-flight events and any pending read response.
  - Inputs are ignored while reset is high.
- Event pipeline:
  - events is registered once (ev_q).
  - A pulse in cycle t increments the counter at the edge ending t+1.
  - The incremented value is visible to a read issued in cycle t+2.
  - Each bit counts at most 1 per cycle; multiple bits high in one cycle update independently.
  - An event held high for k cycles counts k.
- Counter arithmetic:
  - If ev_q[i] is set and ctr[i] != all-ones, then ctr[i] increments by 1.
  - If ev_q[i] is set and ctr[i] == all-ones, ctr[i] holds (saturates) and overflow[i] is set.
  - overflow[i] stays set until counter i is cleared or reset.
- Clear:
  - clr_en with clr_idx < N_EVENTS, or clr_all, sets ctr = 0 and overflow = 0 for the selected counter(s) at the end of that cycle.
  - Clear wins over a same-cycle ev_q increment; that increment is dropped.
  - An ev_q increment in the following cycle counts normally (result 1).
  - clr_en with clr_idx >= N_EVENTS is ignored.
  - clr_en and clr_all together behave as clr_all.
- Read:
  - rd_en in cycle t gives rd_valid = 1 in cycle t+1 and 0 otherwise; fixed 1-cycle latency.
  - Back-to-back reads are allowed at one per cycle.
  - rd_data returns the counter value as of the start of cycle t, i.e. before any same-cycle increment or clear.
  - rd_idx >= N_EVENTS returns rd_data = 0 with rd_valid still asserted.
  - rd_data holds its last value when rd_valid = 0.
- Read and clear of the same counter in the same cycle: the read returns the pre-clear value.
- Bit 63 of rd_data is overflow[idx]. When CTR_WIDTH == 64 the overflow bit is not packed, and bit 63 is counter data.

Test Plan:
- Reset behaviour: pulse events[0] for 5 consecutive cycles, wait 2 cycles, read idx 0 -> rd_valid one cycle later, rd_data = 5. Then assert reset for 1 cycle and read idx 0 -> 0, overflow = 0.
- Event latency: events[11] high at cycle t, rd_en idx 11 at cycle t+1 -> returns 0. rd_en idx 11 at cycle t+2 -> returns 1. Back-to-back reads of idx 0..11 -> 12 responses in 12 consecutive cycles, in request order.
- Saturation (CTR_WIDTH = 4): 20 pulses on events[3] -> rd_data[3:0] = 15, overflow[3] = 1, rd_data[63] = 1. Then clr_en idx 3 -> subsequent read = 0, overflow[3] = 0.
- Clear collision: clr_en idx 7 in the same cycle ev_q[7] = 1, and ev_q[7] = 1 again the next cycle -> counter = 1. Read issued in the clear cycle returns the pre-clear value.
- Concurrency and range: all 12 events high for 3 cycles -> every counter = 3. clr_all -> all 0. rd_idx = 13 -> rd_valid = 1, rd_data = 0. clr_en idx 14 -> no counter changes.

Source files
------------

// File: rtl/cci_mpf_csr_event_counters.sv
// MPF CSR event counters: registers single-cycle event pulses from the shims,
// accumulates each into a saturating counter with a sticky overflow flag, and
// serves indexed reads (1-cycle latency) and single/all clears.
module cci_mpf_csr_event_counters #(
  parameter int unsigned N_EVENTS  = 12,
  parameter int unsigned CTR_WIDTH = 48,
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_EVENTS-1:0]  events,
  input  logic                 rd_en,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_valid,
  output logic [63:0]          rd_data,
  input  logic                 clr_en,
  input  logic [IDX_WIDTH-1:0] clr_idx,
  input  logic                 clr_all,
  output logic [N_EVENTS-1:0]  overflow
);

  logic [N_EVENTS-1:0]  ev_q;
  logic [CTR_WIDTH-1:0] ctr [N_EVENTS];
  logic [63:0]          rd_sel;

  // Register incoming event pulses once before counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_q <= '0;
    end else begin
      ev_q <= events;
    end
  end

  // Per-counter update: clear beats increment; increments saturate at all-ones
  // and latch the sticky overflow flag instead.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      if (reset) begin
        ctr[i]      <= '0;
        overflow[i] <= 1'b0;
      end else if (clr_all || (clr_en && (clr_idx == IDX_WIDTH'(i)))) begin
        ctr[i]      <= '0;
        overflow[i] <= 1'b0;
      end else if (ev_q[i]) begin
        if (ctr[i] == '1) begin
          overflow[i] <= 1'b1;
        end else begin
          ctr[i] <= ctr[i] + CTR_WIDTH'(1);
        end
      end
    end
  end

  // Select and pack the addressed counter; out-of-range indices read as zero.
  // A full 64-bit counter leaves no room for the overflow bit.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) begin
        rd_sel = 64'(ctr[i]);
        if (CTR_WIDTH < 64) begin
          rd_sel[63] = overflow[i];
        end
      end
    end
  end

  // Read response register: one response per request, data held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Self-checking bench for cci_mpf_csr_event_counters. A 4-bit-counter instance
// exercises saturation; a default-width instance shares the same stimulus.
module tb_cci_mpf_csr_event_counters;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] events;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic        clr_en;
  logic [3:0]  clr_idx;
  logic        clr_all;
  logic        rd_valid, rd_valid_w;
  logic [63:0] rd_data, rd_data_w;
  logic [11:0] overflow, overflow_w;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  cci_mpf_csr_event_counters #(.N_EVENTS(12), .CTR_WIDTH(4), .IDX_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .events(events), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .clr_en(clr_en), .clr_idx(clr_idx),
    .clr_all(clr_all), .overflow(overflow)
  );

  cci_mpf_csr_event_counters #(.N_EVENTS(12), .CTR_WIDTH(48), .IDX_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .events(events), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid_w), .rd_data(rd_data_w), .clr_en(clr_en), .clr_idx(clr_idx),
    .clr_all(clr_all), .overflow(overflow_w)
  );

  typedef struct {
    logic        rst;
    logic [11:0] ev;
    logic        rd;
    logic [3:0]  ridx;
    logic        clr;
    logic [3:0]  cidx;
    logic        call;
    logic        chk;
    logic        ev_valid;
    logic [63:0] ed;
    logic [11:0] eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic [11:0] ev, logic rd, logic [3:0] ridx,
                              logic clr, logic [3:0] cidx, logic call,
                              logic chk, logic ev_valid, logic [63:0] ed, logic [11:0] eo);
    vec_t v;
    v.rst = rst; v.ev = ev; v.rd = rd; v.ridx = ridx; v.clr = clr; v.cidx = cidx;
    v.call = call; v.chk = chk; v.ev_valid = ev_valid; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic rst, input logic [11:0] ev, input logic rd,
                       input logic [3:0] ridx, input logic clr, input logic [3:0] cidx,
                       input logic call);
    reset = rst; events = ev; rd_en = rd; rd_idx = ridx;
    clr_en = clr; clr_idx = cidx; clr_all = call;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(0, '0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    reset = 1'b1; events = '0; rd_en = 1'b0; rd_idx = '0;
    clr_en = 1'b0; clr_idx = '0; clr_all = 1'b0;

    // Reset, accumulate 5, read, reset again (inputs ignored during reset).
    add(1, 12'h000, 0, 0, 0, 0, 0, 1, 0, 64'd0, 12'h000);
    for (int i = 0; i < 5; i++) add(0, 12'h001, 0, 0, 0, 0, 0, 1, 0, 64'd0, 12'h000);
    add(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 64'd0, 12'h000);
    add(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 64'd0, 12'h000);
    add(0, 12'h000, 1, 0, 0, 0, 0, 1, 1, 64'd5, 12'h000);
    add(0, 12'h000, 0, 0, 0, 0, 0, 1, 0, 64'd5, 12'h000);
    add(1, 12'h001, 1, 0, 0, 0, 0, 1, 0, 64'd0, 12'h000);
    add(0, 12'h000, 1, 0, 0, 0, 0, 1, 1, 64'd0, 12'h000);
    // Event latency on bit 11, then back-to-back reads 0..11.
    add(0, 12'h800, 0, 0, 0, 0, 0, 1, 0, 64'd0, 12'h000);
    add(0, 12'h000, 1, 11, 0, 0, 0, 1, 1, 64'd0, 12'h000);
    add(0, 12'h000, 1, 11, 0, 0, 0, 1, 1, 64'd1, 12'h000);
    for (int i = 0; i < 12; i++)
      add(0, 12'h000, 1, 4'(i), 0, 0, 0, 1, 1, (i == 11) ? 64'd1 : 64'd0, 12'h000);
    // All events for 3 cycles, range checks, clr_all (with clr_en).
    for (int i = 0; i < 3; i++) add(0, 12'hFFF, 0, 0, 0, 0, 0, 0, 0, 64'd0, 12'h000);
    add(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 64'd0, 12'h000);
    add(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 64'd0, 12'h000);
    add(0, 12'h000, 1, 0, 0, 0, 0, 1, 1, 64'd3, 12'h000);
    add(0, 12'h000, 1, 11, 0, 0, 0, 1, 1, 64'd4, 12'h000);
    add(0, 12'h000, 1, 13, 0, 0, 0, 1, 1, 64'd0, 12'h000);
    add(0, 12'h000, 0, 0, 1, 14, 0, 1, 0, 64'd0, 12'h000);
    add(0, 12'h000, 1, 5, 0, 0, 0, 1, 1, 64'd3, 12'h000);
    add(0, 12'h000, 1, 10, 0, 0, 0, 1, 1, 64'd3, 12'h000);
    add(0, 12'h000, 0, 0, 1, 2, 1, 1, 0, 64'd3, 12'h000);
    add(0, 12'h000, 1, 0, 0, 0, 0, 1, 1, 64'd0, 12'h000);
    add(0, 12'h000, 1, 11, 0, 0, 0, 1, 1, 64'd0, 12'h000);
    add(0, 12'h000, 1, 2, 0, 0, 0, 1, 1, 64'd0, 12'h000);

    foreach (tbl[r]) begin
      drive(tbl[r].rst, tbl[r].ev, tbl[r].rd, tbl[r].ridx, tbl[r].clr, tbl[r].cidx, tbl[r].call);
      if (tbl[r].chk) begin
        check($sformatf("row%0d rd_valid", r), 64'(rd_valid), 64'(tbl[r].ev_valid));
        check($sformatf("row%0d rd_data", r), rd_data, tbl[r].ed);
        check($sformatf("row%0d overflow", r), 64'(overflow), 64'(tbl[r].eo));
        if (tbl[r].rd) check($sformatf("row%0d rd_data_w", r), rd_data_w, tbl[r].ed);
      end
    end

    // Saturation: 20 pulses on bit 3 (4-bit counter saturates at 15).
    for (int i = 0; i < 20; i++) drive(0, 12'h008, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 12'h000, 1, 3, 0, 0, 0);
    check("sat rd_valid", 64'(rd_valid), 64'd1);
    check("sat rd_data", rd_data, 64'h8000_0000_0000_000F);
    check("sat overflow", 64'(overflow), 64'h008);
    check("sat wide rd_data", rd_data_w, 64'd20);
    check("sat wide overflow", 64'(overflow_w), 64'h000);
    drive(0, 12'h000, 0, 0, 1, 3, 0);
    check("sat clr overflow", 64'(overflow), 64'h000);
    drive(0, 12'h000, 1, 3, 0, 0, 0);
    check("sat clr rd_data", rd_data, 64'd0);

    // Clear collision on counter 7 (starts at 2).
    drive(0, 12'h080, 0, 0, 0, 0, 0);
    drive(0, 12'h080, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 12'h080, 0, 0, 0, 0, 0);
    drive(0, 12'h080, 1, 7, 1, 7, 0);
    check("coll pre-clear read", rd_data, 64'd2);
    check("coll rd_valid", 64'(rd_valid), 64'd1);
    drive(0, 12'h000, 0, 0, 0, 0, 0);
    check("coll rd_valid low", 64'(rd_valid), 64'd0);
    check("coll rd_data hold", rd_data, 64'd2);
    drive(0, 12'h000, 1, 7, 0, 0, 0);
    check("coll post-clear count", rd_data, 64'd1);
    check("coll wide count", rd_data_w, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
